// File: rtl/cv32e40s_data_obi_arbiter_if.sv
// Data-side OBI payload types and the bundle of requester/adapter signals seen by the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
package cv32e40s_data_obi_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_data_resp_t;
endpackage

interface cv32e40s_data_obi_arbiter_if #(
  parameter int CNT_WIDTH = 2
);
  import cv32e40s_data_obi_arbiter_pkg::*;

  logic                 p0_valid_i;
  logic                 p0_ready_o;
  obi_data_req_t        p0_trans_i;
  logic                 p1_valid_i;
  logic                 p1_ready_o;
  obi_data_req_t        p1_trans_i;
  logic                 trans_valid_o;
  logic                 trans_ready_i;
  obi_data_req_t        trans_o;
  logic                 resp_valid_i;
  obi_data_resp_t       resp_i;
  logic                 p0_resp_valid_o;
  logic                 p1_resp_valid_o;
  obi_data_resp_t       resp_o;
  logic [CNT_WIDTH-1:0] outstnd_cnt_o;
  logic                 resp_err_o;

  modport slave (
    input  p0_valid_i, p0_trans_i, p1_valid_i, p1_trans_i,
    input  trans_ready_i, resp_valid_i, resp_i,
    output p0_ready_o, p1_ready_o, trans_valid_o, trans_o,
    output p0_resp_valid_o, p1_resp_valid_o, resp_o, outstnd_cnt_o, resp_err_o
  );

  modport master (
    output p0_valid_i, p0_trans_i, p1_valid_i, p1_trans_i,
    output trans_ready_i, resp_valid_i, resp_i,
    input  p0_ready_o, p1_ready_o, trans_valid_o, trans_o,
    input  p0_resp_valid_o, p1_resp_valid_o, resp_o, outstnd_cnt_o, resp_err_o
  );
endinterface

// File: rtl/cv32e40s_data_obi_arbiter.sv
// Two-port arbiter in front of the data OBI adapter: locks the owner until grant and routes
// in-order responses via an ID FIFO. Define CV32E40S_DOBI_ARB_RR_EN for round-robin IDLE selection.
module cv32e40s_data_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic                        clk,
  input logic                        rst,
  cv32e40s_data_obi_arbiter_if.slave bus
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;

  logic full, empty;
  logic sel_valid, sel_id;
  logic trans_valid, accept, pop;
  logic pref;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

`ifdef CV32E40S_DOBI_ARB_RR_EN
  logic rr_q;

  // After each accept the other port becomes preferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (accept) begin
      rr_q <= ~sel_id;
    end
  end

  assign pref = rr_q;
`else
  assign pref = 1'b0;
`endif

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    state_d   = state_q;

    case (state_q)
      LOCK0: begin
        sel_valid = bus.p0_valid_i;
        sel_id    = 1'b0;
      end
      LOCK1: begin
        sel_valid = bus.p1_valid_i;
        sel_id    = 1'b1;
      end
      default: begin
        if (pref && bus.p1_valid_i) begin
          sel_valid = 1'b1;
          sel_id    = 1'b1;
        end else if (bus.p0_valid_i) begin
          sel_valid = 1'b1;
          sel_id    = 1'b0;
        end else if (bus.p1_valid_i) begin
          sel_valid = 1'b1;
          sel_id    = 1'b1;
        end
      end
    endcase

    // Full gating uses only registered state, so a response never frees a slot same-cycle.
    trans_valid = sel_valid && !full && !rst;
    accept      = trans_valid && bus.trans_ready_i;

    case (state_q)
      IDLE: begin
        if (trans_valid && !bus.trans_ready_i) begin
          state_d = sel_id ? LOCK1 : LOCK0;
        end
      end
      default: begin
        if (!trans_valid || bus.trans_ready_i) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign pop = bus.resp_valid_i && !empty && !rst;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
    end
  end

  // Slot contents need no reset: occupancy is tracked by the counter and pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_fifo_q[wptr_q] <= sel_id;
    end
  end

  assign bus.trans_valid_o   = trans_valid;
  assign bus.trans_o         = sel_id ? bus.p1_trans_i : bus.p0_trans_i;
  assign bus.p0_ready_o      = accept && !sel_id;
  assign bus.p1_ready_o      = accept && sel_id;
  assign bus.p0_resp_valid_o = pop && !id_fifo_q[rptr_q];
  assign bus.p1_resp_valid_o = pop && id_fifo_q[rptr_q];
  assign bus.resp_o          = bus.resp_i;
  assign bus.resp_err_o      = bus.resp_valid_i && empty && !rst;
  assign bus.outstnd_cnt_o   = cnt_q;
endmodule

// File: tb/tb_cv32e40s_data_obi_arbiter.sv
// Bench for the data OBI arbiter: directed scenarios then random traffic, checked each
// cycle against a queue-based model of ownership, grants and in-order response routing.
module tb_cv32e40s_data_obi_arbiter;
  import cv32e40s_data_obi_arbiter_pkg::*;

  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  cv32e40s_data_obi_arbiter_if #(.CNT_WIDTH(CW)) bus ();

  cv32e40s_data_obi_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of issuing port IDs, current locked owner (-1 = none), RR preference.
  int q[$];
  int owner;
  int rrp;
  bit rr_en;

  function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic obi_data_req_t rand_req();
    obi_data_req_t r;
    r.addr  = $urandom;
    r.we    = 1'($urandom);
    r.be    = 4'($urandom);
    r.wdata = $urandom;
    return r;
  endfunction

  // Apply one cycle of inputs, check outputs mid-cycle, advance the model at the clock edge.
  task automatic step(input logic r, input logic v0, input logic v1, input logic tr, input logic rv);
    int   cand;
    bit   cand_v;
    bit   full;
    bit   e_tv, e_acc, e_pop, e_err;
    int   e_head;
    rst               = r;
    bus.p0_valid_i    = v0;
    bus.p1_valid_i    = v1;
    bus.trans_ready_i = tr;
    bus.resp_valid_i  = rv;
    bus.resp_i.rdata  = $urandom;
    bus.resp_i.err    = 1'($urandom);
    #4;
    full   = (q.size() == MAXO);
    cand   = 0;
    cand_v = 0;
    if (owner >= 0) begin
      cand   = owner;
      cand_v = (owner == 0) ? v0 : v1;
    end else if (rr_en && rrp == 1) begin
      if (v1) begin cand = 1; cand_v = 1; end
      else if (v0) begin cand = 0; cand_v = 1; end
    end else begin
      if (v0) begin cand = 0; cand_v = 1; end
      else if (v1) begin cand = 1; cand_v = 1; end
    end
    e_tv   = cand_v && !full && !r;
    e_acc  = e_tv && tr;
    e_pop  = rv && !r && (q.size() > 0);
    e_err  = rv && !r && (q.size() == 0);
    e_head = (q.size() > 0) ? q[0] : 0;

    chk("trans_valid", 128'(bus.trans_valid_o), 128'(e_tv));
    chk("p0_ready", 128'(bus.p0_ready_o), 128'(e_acc && cand == 0));
    chk("p1_ready", 128'(bus.p1_ready_o), 128'(e_acc && cand == 1));
    if (e_tv) chk("trans_o", 128'(bus.trans_o), 128'((cand == 1) ? bus.p1_trans_i : bus.p0_trans_i));
    chk("p0_resp_valid", 128'(bus.p0_resp_valid_o), 128'(e_pop && e_head == 0));
    chk("p1_resp_valid", 128'(bus.p1_resp_valid_o), 128'(e_pop && e_head == 1));
    chk("resp_err", 128'(bus.resp_err_o), 128'(e_err));
    chk("resp_o", 128'(bus.resp_o), 128'(bus.resp_i));
    chk("outstnd_cnt", 128'(bus.outstnd_cnt_o), 128'(q.size()));

    @(posedge clk);
    if (r) begin
      q.delete();
      owner = -1;
      rrp   = 0;
    end else begin
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        q.push_back(cand);
        rrp   = (cand == 0) ? 1 : 0;
        owner = -1;
      end else if (e_tv) begin
        owner = cand;
      end else begin
        owner = -1;
      end
    end
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    owner       = -1;
    rrp         = 0;
`ifdef CV32E40S_DOBI_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    rst               = 1'b1;
    bus.p0_valid_i    = 1'b0;
    bus.p1_valid_i    = 1'b0;
    bus.p0_trans_i    = rand_req();
    bus.p1_trans_i    = rand_req();
    bus.trans_ready_i = 1'b0;
    bus.resp_valid_i  = 1'b0;
    bus.resp_i        = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, inputs active while reset is held.
    step(1, 1, 1, 1, 1);

    // Both valid with immediate grant: port 0 first; with round-robin the second goes to port 1.
    step(0, 1, 1, 1, 0);
    chk("cnt_after_first_grant", 128'(bus.outstnd_cnt_o), 128'(1));
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Port 1 locked across a 3-cycle stall while port 0 joins in cycle 2.
    bus.p0_trans_i = rand_req();
    bus.p1_trans_i = rand_req();
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0);

    // Fill to the limit: a pending request is held off; a response frees the slot next cycle.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    chk("full_holds_off", 128'(bus.trans_valid_o), 128'(0));
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Response order {1,0,1}, including accept and response together at count 1.
    step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("cnt_push_pop", 128'(bus.outstnd_cnt_o), 128'(1));
    step(0, 0, 0, 0, 1);

    // Spurious response at count 0.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Reset with two outstanding and a lock pending; later responses are spurious.
    step(0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1);

    // Random traffic including stalls, dropped valids, spurious responses and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.p0_trans_i = rand_req();
      if ($urandom_range(0, 3) == 0) bus.p1_trans_i = rand_req();
      step(($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 55),
           1'($urandom_range(0, 99) < 45));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
